dm_mc: RTL

- Multi-cycle data memory for the next-generation (multi-cycle/stalling) MIPS core.
- Replaces the single-cycle byte-capable data memory. Adds:
  - parametrised depth and wait states;
  - a req/ready handshake, so the core can stall;
  - load sign/zero extension inside the block;
  - misalignment and illegal-size detection.
- Sits between the ALU address path and the core's write-back mux.

---
 rtl/dm_pkg.sv | 10 +
 rtl/dm_mc_if.sv | 16 +
 rtl/dm_lane_unit.sv | 26 ++
 rtl/dm_mc.sv | 71 +++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared size/state encodings and the alignment rule for dm_mc
package dm_pkg;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      return (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'b00) || size == 2'b11;
   endfunction
endpackage

// File: rtl/dm_mc_if.sv
// dm_mc_if: request/response bundle between the core and the multi-cycle data memory
interface dm_mc_if #(parameter int ADDR_W = 14);
   logic              req;
   logic              we;
   logic [1:0]        size;
   logic              sign;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       pc;
   logic [31:0]       rdata;
   logic              ready;
   logic              busy;
   logic              misalign;
   modport master (output req, we, size, sign, addr, wdata, pc, input rdata, ready, busy, misalign);
   modport slave  (input req, we, size, sign, addr, wdata, pc, output rdata, ready, busy, misalign);
endinterface

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: byte/half lane merge for stores, lane extract plus extension for loads
module dm_lane_unit
   import dm_pkg::*;
(
   input  logic [31:0] old_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  lane_i,
   input  logic [1:0]  size_i,
   input  logic        sign_i,
   output logic [31:0] merged_o,
   output logic [31:0] load_o,
   output logic        misalign_o
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   always_comb begin
      byte_v = old_i[{lane_i, 3'b000} +: 8];
      half_v = lane_i[1] ? old_i[31:16] : old_i[15:0];
      load_o = size_i == SZ_BYTE ? {{24{sign_i & byte_v[7]}}, byte_v} :
               size_i == SZ_HALF ? {{16{sign_i & half_v[15]}}, half_v} : old_i;
      merged_o = size_i == SZ_WORD ? wdata_i : old_i;
      if (size_i == SZ_BYTE) merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      if (size_i == SZ_HALF) merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      misalign_o = misaligned(size_i, lane_i);
   end
endmodule

// File: rtl/dm_mc.sv
// dm_mc: multi-cycle data memory with req/ready handshake, wait states and load extension
// Store and rdata capture happen on the edge leaving DONE; rdata bypasses the load value during DONE.
module dm_mc
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = 3072,
   parameter int ADDR_W      = 14,
   parameter int WAIT_CYCLES = 2,
   parameter bit LOG_EN      = 1'b1
) (
   input  logic   clk,
   input  logic   reset,
   dm_mc_if.slave bus
);
   localparam int IW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
   typedef struct packed {
      logic              we;
      logic [1:0]        size;
      logic              sign;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [31:0]       pc;
   } req_t;
   state_t      state_d, state_q;
   logic [3:0]  cnt_d, cnt_q;
   req_t        lat_d, lat_q;
   logic [31:0] rdata_d, rdata_q;
   logic [31:0] mem_q [DEPTH_WORDS];
   logic [IW-1:0] idx;
   logic [31:0] old_w, merged_w, load_w;
   logic        mis_w, accept, commit;
   dm_lane_unit u_lane (
      .old_i(old_w), .wdata_i(lat_q.wdata), .lane_i(lat_q.addr[1:0]), .size_i(lat_q.size),
      .sign_i(lat_q.sign), .merged_o(merged_w), .load_o(load_w), .misalign_o(mis_w)
   );
   always_comb begin
      accept  = state_q == S_IDLE && bus.req;
      commit  = state_q == S_DONE;
      state_d = state_q == S_IDLE ? (bus.req ? (WAIT_CYCLES > 0 ? S_WAIT : S_DONE) : S_IDLE) :
                state_q == S_WAIT ? (cnt_q == 4'd0 ? S_DONE : S_WAIT) : S_IDLE;
      cnt_d   = state_q == S_IDLE ? CNT_INIT : cnt_q - 4'(cnt_q != 4'd0);
      lat_d   = accept ? '{bus.we, bus.size, bus.sign, bus.addr, bus.wdata, bus.pc} : lat_q;
      idx     = IW'(32'(lat_q.addr[ADDR_W-1:2]) % DEPTH_WORDS);
      old_w   = mem_q[idx];
      rdata_d = commit && !lat_q.we && !mis_w ? load_w : rdata_q;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         rdata_q <= rdata_d;
         if (commit && lat_q.we && !mis_w) mem_q[idx] <= merged_w;
      end
   end
`ifndef SYNTHESIS
   always_ff @(posedge clk)
      if (LOG_EN && reset && commit && lat_q.we && !mis_w)
         $display("@%h: *%h <= %h", lat_q.pc, 32'({lat_q.addr[ADDR_W-1:2], 2'b00}), merged_w);
`endif
   assign bus.ready    = commit;
   assign bus.busy     = state_q != S_IDLE;
   assign bus.misalign = commit && mis_w;
   assign bus.rdata    = rdata_d;
endmodule
